uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
- Drains bytes from the UART receiver's internal FIFO using the NxT / Rx_EMPTY / O_DATA handshake.
- Parses host configuration frames: SYNC 0xA5, ADDR, LEN, LEN payload bytes, CHK.
- Validates each frame, then commits the payload as sequential register writes on a ready/valid config bus.
- Sits between UART_Rx and the sniffer's configuration register file. It is the only consumer of the Rx FIFO.

Parameters:
- MAX_LEN, 8, maximum payload bytes per frame (1..16); also sets the depth of the payload buffer.
- TIMEOUT, 16'd50000, clk cycles allowed between consecutive bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  reference clock (single clock domain).
- rst  in  1  reset, asynchronous, active-low.
- Rx_EMPTY  in  1  Rx FIFO empty flag.
- O_DATA  in  8  Rx FIFO read data; valid the cycle after NxT.
- NxT  out  1  one-cycle pop request to the Rx FIFO.
- cfg_wr  out  1  config write valid.
- cfg_ready  in  1  config sink accepts the write this cycle.
- cfg_addr  out  8  config write address.
- cfg_data  out  8  config write data.
- frame_ok  out  1  one-cycle pulse when a frame commits fully.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- err_code  out  2  last error: 0 none, 1 BAD_LEN, 2 BAD_CHK, 3 TIMEOUT.
- err_cnt  out  8  rejected-frame count, saturates at 255.
- busy  out  1  high whenever the FSM is not in HUNT.

Behaviour:
- Reset (async, rst=0): FSM to HUNT. All outputs 0. Payload buffer, checksum and timeout counter cleared. A byte in flight is discarded. The Rx FIFO contents are not touched.
- Fetch handshake:
  - NxT=1 for one cycle at t when Rx_EMPTY=0, no fetch is outstanding and FSM≠COMMIT.
  - O_DATA is sampled at t+1 as byte_vld.
  - The next NxT comes no earlier than t+2, i.e. max one byte per 2 clk. This guarantees Rx_EMPTY reflects the pop.
- HUNT: bytes ≠0xA5 are discarded silently. 0xA5 → ADDR; chk cleared to 0.
- ADDR: latch addr, chk^=byte → LEN.
- LEN:
  - byte==0 or byte>MAX_LEN → error BAD_LEN, back to HUNT.
  - Otherwise latch len, chk^=byte, idx=0 → DATA.
- DATA:
  - buf[idx]=byte, chk^=byte, idx++.
  - When idx reaches len → CHK.
  - 0xA5 inside the payload is ordinary data.
- CHK:
  - byte==chk → COMMIT, idx=0.
  - Otherwise error BAD_CHK → HUNT.
- COMMIT:
  - cfg_wr=1, cfg_addr=(addr+idx) mod 256 (8-bit wrap), cfg_data=buf[idx].
  - The beat completes on the cycle where cfg_wr&cfg_ready. Only then does idx advance.
  - Outputs are held stable while cfg_ready=0, with no timeout in COMMIT.
  - After the last beat: cfg_wr=0 next cycle, frame_ok pulses in the cycle after the last accepted beat, err_code=0 → HUNT.
  - No NxT is issued during COMMIT. The FIFO buffers incoming bytes.
- Timeout:
  - Counter runs in ADDR/LEN/DATA/CHK and reloads to 0 on every byte_vld.
  - On reaching TIMEOUT → error TIMEOUT → HUNT.
  - If byte_vld and timeout occur in the same cycle, the byte wins.
- Error action (one cycle):
  - frame_err=1, err_code updated.
  - err_cnt+1 unless already 255.
  - No cfg_wr is ever issued for a rejected frame.
- Reset mid-COMMIT: remaining beats are dropped and frame_ok is not pulsed.

Decomposition:
- Package uart_rx_frame_pkg:
  - SYNC_BYTE=8'hA5.
  - FSM state encodings HUNT/ADDR/LEN/DATA/CHK/COMMIT.
  - err_code constants.
- Sub-module rx_fifo_fetch: implements the NxT / O_DATA handshake and outputs byte_vld/byte, gated by a fetch_en input from the FSM.
- Frame FSM, payload buffer and commit logic stay in the top module.

Test Plan:
- Bytes A5 10 02 11 22 CHK=21 (chk = 10^02^11^22), cfg_ready=1 → writes (10,11) then (11,22), frame_ok once, err_cnt=0, NxT never while Rx_EMPTY=1.
- Leading garbage 00 FF then A5 FE 02 AA BB CHK=ED, cfg_ready low 3 cycles on beat 0 → beat 0 held stable. Writes land at FE, then FF.
- A5 10 02 11 22 with CHK=00 → frame_err, err_code=2, err_cnt=1, no cfg_wr.
- A5 10 00, and A5 10 (MAX_LEN+1) → each gives err_code=1. The next valid frame is accepted normally.
- A5 10 02 11, then the FIFO stays empty for TIMEOUT cycles → err_code=3, busy falls. Then a full valid frame → frame_ok.
- rst=0 asserted mid-COMMIT → all outputs 0 immediately, no frame_ok. A following frame with payload 0xA5 inside (A5 01 01 A5 A5) commits (01,A5).

Source files
------------

// File: rtl/uart_rx_frame_pkg.sv
// rtl/uart_rx_frame_pkg.sv - shared constants and types for the UART config-frame receiver
//
// Purpose: sync byte, frame FSM state encoding and error codes shared by the
// frame controller and its testbench-facing outputs.
package uart_rx_frame_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LEN    = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] ERR_BAD_CHK = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/rx_fifo_fetch.sv
// rtl/rx_fifo_fetch.sv - pop handshake towards the UART Rx FIFO
//
// Purpose: issues single-cycle NxT pops while enabled and presents the popped
// byte one cycle later as byte_vld/byte_data. At most one pop is outstanding,
// so pops are spaced at least two cycles apart and Rx_EMPTY has caught up.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   fetch_en        controller allows a new pop
//   Rx_EMPTY        FIFO empty flag
//   O_DATA          FIFO read data, valid the cycle after NxT
//   NxT             pop request
//   byte_vld        byte_data holds a freshly popped byte
//   byte_data       popped byte
module rx_fifo_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       fetch_en,
  input  logic       Rx_EMPTY,
  input  logic [7:0] O_DATA,
  output logic       NxT,
  output logic       byte_vld,
  output logic [7:0] byte_data
);

  logic r_pending;

  // rst gates the pop so nothing leaves the FIFO while reset is held.
  assign NxT       = rst & fetch_en & ~Rx_EMPTY & ~r_pending;
  assign byte_vld  = r_pending;
  assign byte_data = O_DATA;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= NxT;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - host config-frame parser and register-write committer
//
// Purpose: drains the UART Rx FIFO, parses frames A5/ADDR/LEN/payload/CHK
// (CHK = XOR of ADDR, LEN and payload), and commits a validated payload as
// sequential ready/valid writes to addresses ADDR, ADDR+1, ... (8-bit wrap).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   Rx_EMPTY, O_DATA, NxT    Rx FIFO pop interface
//   cfg_wr/cfg_ready         config write handshake
//   cfg_addr, cfg_data       config write beat
//   frame_ok, frame_err      one-cycle frame result pulses
//   err_code, err_cnt        last error and saturating rejected-frame count
//   busy                     frame in progress (FSM not hunting)
module uart_rx_frame_ctrl
  import uart_rx_frame_pkg::*;
#(
  parameter int          MAX_LEN = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx_EMPTY,
  input  logic [7:0] O_DATA,
  output logic       NxT,
  output logic       cfg_wr,
  input  logic       cfg_ready,
  output logic [7:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt,
  output logic       busy
);

  localparam int         IW        = $clog2(MAX_LEN + 1);
  localparam int         BIW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_addr;
  logic [IW-1:0]   r_len;
  logic [IW-1:0]   r_idx;
  logic [7:0]      r_chk;
  logic [7:0]      r_buf [MAX_LEN];
  logic [15:0]     r_tmo;
  logic [1:0]      r_err_code;
  logic [7:0]      r_err_cnt;
  logic            r_frame_ok;
  logic            r_frame_err;

  logic            w_byte_vld;
  logic [7:0]      w_byte;
  logic            w_fetch_en;
  logic [IW-1:0]   w_idx_inc;
  logic [BIW-1:0]  w_bidx;
  logic            w_in_frame;
  logic            w_tmo_hit;
  logic            w_err;
  logic [1:0]      w_err_code;
  logic            w_commit_done;

  // The FIFO keeps buffering host bytes while the commit drains.
  assign w_fetch_en = (r_state != ST_COMMIT);

  rx_fifo_fetch u_fetch (
    .clk       (clk),
    .rst       (rst),
    .fetch_en  (w_fetch_en),
    .Rx_EMPTY  (Rx_EMPTY),
    .O_DATA    (O_DATA),
    .NxT       (NxT),
    .byte_vld  (w_byte_vld),
    .byte_data (w_byte)
  );

  assign w_idx_inc  = r_idx + 1'b1;
  assign w_bidx     = r_idx[BIW-1:0];
  assign w_in_frame = (r_state == ST_ADDR) || (r_state == ST_LEN) ||
                      (r_state == ST_DATA) || (r_state == ST_CHK);
  assign w_tmo_hit  = (r_tmo == TIMEOUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A byte arriving in the timeout cycle is handled first, so the timeout
  // branch is only reached when no byte is present.
  always_comb begin
    w_state_nxt   = r_state;
    w_err         = 1'b0;
    w_err_code    = ERR_NONE;
    w_commit_done = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_byte_vld && (w_byte == SYNC_BYTE)) w_state_nxt = ST_ADDR;
      end
      ST_ADDR, ST_LEN, ST_DATA, ST_CHK: begin
        if (w_byte_vld) begin
          case (r_state)
            ST_ADDR: w_state_nxt = ST_LEN;
            ST_LEN: begin
              if ((w_byte == 8'd0) || (w_byte > MAX_LEN_B)) begin
                w_err       = 1'b1;
                w_err_code  = ERR_BAD_LEN;
                w_state_nxt = ST_HUNT;
              end else begin
                w_state_nxt = ST_DATA;
              end
            end
            ST_DATA: begin
              if (w_idx_inc == r_len) w_state_nxt = ST_CHK;
            end
            default: begin
              if (w_byte == r_chk) begin
                w_state_nxt = ST_COMMIT;
              end else begin
                w_err       = 1'b1;
                w_err_code  = ERR_BAD_CHK;
                w_state_nxt = ST_HUNT;
              end
            end
          endcase
        end else if (w_tmo_hit) begin
          w_err       = 1'b1;
          w_err_code  = ERR_TIMEOUT;
          w_state_nxt = ST_HUNT;
        end
      end
      ST_COMMIT: begin
        if (cfg_ready && (w_idx_inc == r_len)) begin
          w_commit_done = 1'b1;
          w_state_nxt   = ST_HUNT;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= 8'd0;
      r_len       <= '0;
      r_idx       <= '0;
      r_chk       <= 8'd0;
      r_tmo       <= 16'd0;
      r_err_code  <= ERR_NONE;
      r_err_cnt   <= 8'd0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'd0;
    end else begin
      r_frame_ok  <= w_commit_done;
      r_frame_err <= w_err;

      if (w_err) begin
        r_err_code <= w_err_code;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else if (w_commit_done) begin
        r_err_code <= ERR_NONE;
      end

      if (w_in_frame && !w_byte_vld && !w_tmo_hit) r_tmo <= r_tmo + 16'd1;
      else                                         r_tmo <= 16'd0;

      case (r_state)
        ST_HUNT: begin
          if (w_byte_vld && (w_byte == SYNC_BYTE)) r_chk <= 8'd0;
        end
        ST_ADDR: begin
          if (w_byte_vld) begin
            r_addr <= w_byte;
            r_chk  <= r_chk ^ w_byte;
          end
        end
        ST_LEN: begin
          if (w_byte_vld && !w_err) begin
            r_len <= w_byte[IW-1:0];
            r_chk <= r_chk ^ w_byte;
            r_idx <= '0;
          end
        end
        ST_DATA: begin
          if (w_byte_vld) begin
            r_buf[w_bidx] <= w_byte;
            r_chk         <= r_chk ^ w_byte;
            r_idx         <= w_idx_inc;
          end
        end
        ST_CHK: begin
          if (w_byte_vld) r_idx <= '0;
        end
        ST_COMMIT: begin
          if (cfg_ready) r_idx <= w_idx_inc;
        end
        default: ;
      endcase
    end
  end

  assign cfg_wr    = (r_state == ST_COMMIT);
  assign cfg_addr  = cfg_wr ? (r_addr + 8'(r_idx)) : 8'd0;
  assign cfg_data  = cfg_wr ? r_buf[w_bidx] : 8'd0;
  assign frame_ok  = r_frame_ok;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign err_cnt   = r_err_cnt;
  assign busy      = (r_state != ST_HUNT);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

  localparam int          MAX_LEN = 8;
  localparam logic [15:0] TMO     = 16'd200;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Rx_EMPTY = 1'b1;
  logic [7:0] O_DATA = 8'd0;
  logic       NxT;
  logic       cfg_wr;
  logic       cfg_ready = 1'b0;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [7:0] err_cnt;
  logic       busy;

  uart_rx_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .Rx_EMPTY  (Rx_EMPTY),
    .O_DATA    (O_DATA),
    .NxT       (NxT),
    .cfg_wr    (cfg_wr),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Rx FIFO model: pop on NxT, data registered, empty flag follows the pop.
  logic [7:0] fifo_q[$];
  always @(posedge clk) begin
    if (NxT && fifo_q.size() > 0) O_DATA <= fifo_q.pop_front();
    Rx_EMPTY <= (fifo_q.size() == 0);
  end

  int total = 0;
  int bad = 0;

  logic [15:0] got_wr[$];
  logic [15:0] exp_wr[$];
  int   n_ok = 0, n_err = 0;
  int   exp_ok = 0, exp_err = 0;
  int   exp_cnt = 0;
  logic [1:0] exp_code = 2'd0;

  int   v_nxt_empty = 0, v_nxt_commit = 0, v_nxt_b2b = 0, v_hold = 0;
  int   rdy_mode = 0;
  int   rdy_low_left = 0;
  logic prev_stall = 1'b0, prev_nxt = 1'b0;
  logic [7:0] prev_addr = 8'd0, prev_data = 8'd0;
  logic [7:0] tx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: observe at the negedge, then drive cfg_ready for the next edge.
  task tick();
    @(negedge clk);
    if (NxT && Rx_EMPTY) v_nxt_empty++;
    if (NxT && cfg_wr) v_nxt_commit++;
    if (NxT && prev_nxt) v_nxt_b2b++;
    if (prev_stall && (!cfg_wr || cfg_addr != prev_addr || cfg_data != prev_data)) v_hold++;
    if (frame_ok) n_ok++;
    if (frame_err) n_err++;
    case (rdy_mode)
      0: cfg_ready = 1'b1;
      1: cfg_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (cfg_wr && rdy_low_left > 0) begin
          cfg_ready = 1'b0;
          rdy_low_left--;
        end else begin
          cfg_ready = 1'b1;
        end
      end
    endcase
    if (cfg_wr && cfg_ready) got_wr.push_back({cfg_addr, cfg_data});
    prev_stall = cfg_wr && !cfg_ready;
    prev_addr  = cfg_addr;
    prev_data  = cfg_data;
    prev_nxt   = NxT;
  endtask

  task send_tx();
    foreach (tx[i]) fifo_q.push_back(tx[i]);
  endtask

  task wait_idle(input int budget);
    int quiet;
    quiet = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (fifo_q.size() == 0 && Rx_EMPTY && !busy && !NxT && !frame_ok && !frame_err) quiet++;
      else quiet = 0;
      if (quiet >= 4) return;
    end
    check("idle_wait_expired", 32'd1, 32'd0);
  endtask

  task note_error(input logic [1:0] code);
    exp_err++;
    if (exp_cnt < 255) exp_cnt++;
    exp_code = code;
  endtask

  // Reference parser: walks the byte stream frame by frame.
  task automatic model_stream(input logic [7:0] s[$]);
    int i;
    int l;
    logic [7:0] a, x;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 2 >= s.size()) break;
      a = s[i+1];
      l = int'(s[i+2]);
      if (l == 0 || l > MAX_LEN) begin
        note_error(2'd1);
        i += 3;
        continue;
      end
      if (i + 3 + l >= s.size()) break;
      x = a ^ 8'(l);
      for (int k = 0; k < l; k++) x ^= s[i+3+k];
      if (x == s[i+3+l]) begin
        for (int k = 0; k < l; k++) exp_wr.push_back({8'(int'(a) + k), s[i+3+k]});
        exp_ok++;
        exp_code = 2'd0;
      end else begin
        note_error(2'd2);
      end
      i += 4 + l;
    end
  endtask

  task check_state(input string tag);
    check({tag, "_nwr"}, got_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++)
      if (i < got_wr.size()) check({tag, "_wr"}, got_wr[i], exp_wr[i]);
    got_wr.delete();
    exp_wr.delete();
    check({tag, "_ok"}, n_ok, exp_ok);
    check({tag, "_err"}, n_err, exp_err);
    check({tag, "_code"}, err_code, exp_code);
    check({tag, "_cnt"}, err_cnt, exp_cnt);
  endtask

  task run_frame(input string tag);
    model_stream(tx);
    send_tx();
    wait_idle(30000);
    check_state(tag);
  endtask

  initial begin
    int n_ok_before;
    int kind, l, ng;
    logic [7:0] a, x, g;

    rst = 1'b0;
    repeat (3) tick();
    #1;
    check("rst_nxt", NxT, 0);
    check("rst_cfg_wr", cfg_wr, 0);
    check("rst_busy", busy, 0);
    check("rst_code", err_code, 0);
    check("rst_cnt", err_cnt, 0);
    check("rst_ok_err", {frame_ok, frame_err}, 0);
    rst = 1'b1;
    tick();

    // Basic frame, always ready.
    rdy_mode = 0;
    tx = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    run_frame("basic");

    // Leading garbage, beat 0 stalled for three cycles, address wrap FE->FF.
    rdy_mode = 2;
    rdy_low_left = 3;
    tx = '{8'h00, 8'hFF, 8'hA5, 8'hFE, 8'h02, 8'hAA, 8'hBB, 8'hED};
    run_frame("stall");
    check("stall_hold", v_hold, 0);
    rdy_mode = 0;

    // Bad checksum.
    tx = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h00};
    run_frame("badchk");

    // Bad lengths, then a good frame.
    tx = '{8'hA5, 8'h10, 8'h00};
    run_frame("len0");
    tx = '{8'hA5, 8'h10, 8'(MAX_LEN + 1)};
    run_frame("lenmax");
    tx = '{8'hA5, 8'h40, 8'h01, 8'h5A, 8'h1B};
    run_frame("after_len");

    // Truncated frame times out.
    tx = '{8'hA5, 8'h10, 8'h02, 8'h11};
    send_tx();
    note_error(2'd3);
    wait_idle(3000);
    check("tmo_busy", busy, 0);
    check_state("tmo");
    tx = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    run_frame("after_tmo");

    // Randomized frame mix with random back-pressure.
    rdy_mode = 1;
    tx.delete();
    for (int f = 0; f < 30; f++) begin
      ng = $urandom_range(0, 2);
      for (int k = 0; k < ng; k++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        tx.push_back(g);
      end
      kind = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 255));
      tx.push_back(8'hA5);
      tx.push_back(a);
      if (kind < 2) begin
        tx.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
      end else begin
        l = $urandom_range(1, MAX_LEN);
        tx.push_back(8'(l));
        x = a ^ 8'(l);
        for (int k = 0; k < l; k++) begin
          g = 8'($urandom_range(0, 255));
          tx.push_back(g);
          x ^= g;
        end
        if (kind < 4) x ^= 8'($urandom_range(1, 255));
        tx.push_back(x);
      end
    end
    run_frame("rand");
    rdy_mode = 0;

    // Error counter saturation.
    tx.delete();
    for (int f = 0; f < 260; f++) begin
      tx.push_back(8'hA5);
      tx.push_back(8'h00);
      tx.push_back(8'h00);
    end
    run_frame("sat");

    // Reset during a stalled commit.
    rdy_mode = 2;
    rdy_low_left = 20;
    tx = '{8'hA5, 8'h30, 8'h02, 8'h01, 8'h02, 8'h31};
    send_tx();
    for (int c = 0; c < 200 && !cfg_wr; c++) tick();
    check("pre_rst_cfg_wr", cfg_wr, 1);
    n_ok_before = n_ok;
    rst = 1'b0;
    prev_stall = 1'b0;
    #1;
    check("mid_rst_cfg_wr", cfg_wr, 0);
    check("mid_rst_addr_data", {cfg_addr, cfg_data}, 0);
    check("mid_rst_busy_nxt", {busy, NxT}, 0);
    check("mid_rst_code_cnt", {err_code, err_cnt}, 0);
    rdy_mode = 0;
    tick();
    rst = 1'b1;
    repeat (5) tick();
    check("rst_no_ok", n_ok, n_ok_before);
    check("rst_no_wr", got_wr.size(), 0);
    exp_cnt = 0;
    exp_code = 2'd0;

    tx = '{8'hA5, 8'h01, 8'h01, 8'hA5, 8'hA5};
    run_frame("a5_payload");

    check("nxt_when_empty", v_nxt_empty, 0);
    check("nxt_in_commit", v_nxt_commit, 0);
    check("nxt_back_to_back", v_nxt_b2b, 0);
    check("hold_stable", v_hold, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
